// File: rtl/can_pkg.sv
// can_pkg
// Shared constants for the CAN bit-stuffing path. The transmit stuffer and
// the receive-side stuff error checker both take their run length from
// STUFF_LEN_DEF so the two directions can never disagree.
//
// Contents:
//   STUFF_LEN_DEF  run of equal bits that forces a stuff bit
//   RECESSIVE      bus level 1
//   DOMINANT       bus level 0
//   stuff_step_e   which action the stuffer takes on the next bit edge
package can_pkg;

  localparam int   STUFF_LEN_DEF = 5;
  localparam logic RECESSIVE     = 1'b1;
  localparam logic DOMINANT      = 1'b0;

  // Action selected for the coming SP edge. Reset is listed so that a
  // debug view can show it, even though reset overrides the decode.
  typedef enum logic [1:0] {
    STEP_IDLE  = 2'd0,
    STEP_SEND  = 2'd1,
    STEP_STUFF = 2'd2,
    STEP_RESET = 2'd3
  } stuff_step_e;

endpackage : can_pkg

// File: rtl/can_bit_stuffer_if.sv
// can_bit_stuffer_if
// Bundle between the frame serializer, the bit stuffer and the bus driver.
//
// Handshake: TX_DATA is transferred on an SP rising edge exactly when
// TX_VALID and TX_READY are both high at that edge. TX_READY depends only
// on stuffer registers, never on TX_VALID. While TX_READY is low the
// serializer must hold TX_DATA/TX_VALID/F_STF unchanged and retry.
//
// Signals:
//   TX_DATA    serializer -> stuffer  next unstuffed bit (0 = dominant)
//   TX_VALID   serializer -> stuffer  TX_DATA holds a bit
//   F_STF      serializer -> stuffer  bit being accepted lies in the stuffing region
//   TX_READY   stuffer -> serializer  bit accepted on this edge
//   TX         stuffer -> bus         stuffed bit stream (registered)
//   STUFF_BIT  stuffer -> bus         TX currently carries an inserted stuff bit
//   dbg_step   stuffer -> observers   action decoded for the coming edge
interface can_bit_stuffer_if;
  import can_pkg::*;

  logic        TX_DATA;
  logic        TX_VALID;
  logic        F_STF;
  logic        TX_READY;
  logic        TX;
  logic        STUFF_BIT;
  stuff_step_e dbg_step;

  // Serializer side.
  modport master (
    output TX_DATA, TX_VALID, F_STF,
    input  TX_READY, TX, STUFF_BIT, dbg_step
  );

  // Stuffer side.
  modport slave (
    input  TX_DATA, TX_VALID, F_STF,
    output TX_READY, TX, STUFF_BIT, dbg_step
  );

endinterface : can_bit_stuffer_if

// File: rtl/can_bit_stuffer.sv
// can_bit_stuffer
// Transmit-side CAN bit stuffer. Takes the unstuffed serializer stream and
// drives the bus TX line; after STUFF_LEN consecutive equal bits inside the
// stuffing region it inserts one complementary stuff bit.
//
// Parameters:
//   STUFF_LEN  run length that forces a stuff bit
//   CNT_W      width of the run counter, must hold STUFF_LEN
//
// Ports:
//   SP     bit-rate clock, one rising edge per CAN bit time
//   reset  synchronous active-high reset
//   bus    can_bit_stuffer_if.slave (data handshake, TX outputs, debug step)
module can_bit_stuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int CNT_W     = 3
) (
  input  logic                SP,
  input  logic                reset,
  can_bit_stuffer_if.slave    bus
);

  // Length and value of the current run of equal bits already on TX.
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_tx;
  logic             r_stuff_bit;

  logic             w_stuff_pending;
  logic [CNT_W-1:0] w_cnt_send;
  stuff_step_e      w_step;

  assign w_stuff_pending = (r_cnt == CNT_W'(STUFF_LEN));

  // Inside the region a repeated bit extends the run, a changed bit starts a
  // new run of one. Outside the region the run is forgotten entirely.
  assign w_cnt_send = !bus.F_STF            ? '0 :
                      (bus.TX_DATA == r_last) ? r_cnt + 1'b1 :
                                              CNT_W'(1);

  // A pending stuff bit wins over everything but reset, regardless of
  // TX_VALID or F_STF; this is what emits a stuff bit after the last CRC bit.
  always_comb begin
    w_step = STEP_IDLE;
    if (reset) begin
      w_step = STEP_RESET;
    end else if (w_stuff_pending) begin
      w_step = STEP_STUFF;
    end else if (bus.TX_VALID) begin
      w_step = STEP_SEND;
    end
  end

  always_ff @(posedge SP) begin
    case (w_step)
      STEP_STUFF: begin
        // The stuff bit is itself the first bit of the next run.
        r_tx        <= ~r_last;
        r_stuff_bit <= 1'b1;
        r_last      <= ~r_last;
        r_cnt       <= CNT_W'(1);
      end
      STEP_SEND: begin
        r_tx        <= bus.TX_DATA;
        r_stuff_bit <= 1'b0;
        r_last      <= bus.TX_DATA;
        r_cnt       <= w_cnt_send;
      end
      default: begin
        // Reset and idle both park the line recessive with no run history.
        r_tx        <= RECESSIVE;
        r_stuff_bit <= 1'b0;
        r_last      <= RECESSIVE;
        r_cnt       <= '0;
      end
    endcase
  end

  assign bus.TX_READY  = !w_stuff_pending;
  assign bus.TX        = r_tx;
  assign bus.STUFF_BIT = r_stuff_bit;
  assign bus.dbg_step  = w_step;

endmodule : can_bit_stuffer
